// File: rtl/quadrilatero_lsu_issue_ctrl.sv
// In-order LSU issue queue feeding N_UNITS loader/storer units round-robin.
// Define QUADRILATERO_LSU_FALL_THROUGH_EN for same-cycle bypass on an empty queue.
module quadrilatero_lsu_issue_ctrl #(
    parameter int N_SLOTS     = 4,
    parameter int N_UNITS     = 2,
    parameter int INSTR_WIDTH = 32,
    parameter int CONF_WIDTH  = 32,
    parameter int FULL_MARGIN = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            flush_i,
    input  logic                            dispatch_i,
    input  logic [INSTR_WIDTH-1:0]          dispatched_instr_i,
    input  logic [CONF_WIDTH-1:0]           csr_config_i,
    output logic                            issue_queue_full_o,
    output logic [$clog2(N_SLOTS+1)-1:0]    usage_o,
    output logic                            overflow_o,
    input  logic [N_UNITS-1:0]              busy_i,
    output logic [N_UNITS-1:0]              start_o,
    output logic [N_UNITS*INSTR_WIDTH-1:0]  issued_instr_o,
    output logic [N_UNITS*CONF_WIDTH-1:0]   issued_instr_conf_o
);
    localparam int PTR_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W  = $clog2(N_SLOTS + 1);
    localparam int UNIT_W = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
    localparam logic [CNT_W-1:0]  SLOTS     = CNT_W'(N_SLOTS);
    localparam logic [CNT_W-1:0]  FULL_THR  = CNT_W'(N_SLOTS - FULL_MARGIN);
    localparam logic [PTR_W-1:0]  LAST_SLOT = PTR_W'(N_SLOTS - 1);
    localparam logic [UNIT_W-1:0] LAST_UNIT = UNIT_W'(N_UNITS - 1);

    logic [INSTR_WIDTH-1:0] instr_q [N_SLOTS];
    logic [CONF_WIDTH-1:0]  conf_q  [N_SLOTS];
    logic [PTR_W-1:0]       rd_ptr, wr_ptr;
    logic [CNT_W-1:0]       count;
    logic [UNIT_W-1:0]      rr_ptr, sel;
    logic [N_UNITS-1:0]     start_q, elig;
    logic                   overflow_q, any_elig, has_head, push, pop;
    logic [INSTR_WIDTH-1:0] head_instr;
    logic [CONF_WIDTH-1:0]  head_conf;
    logic [N_UNITS*INSTR_WIDTH-1:0] instr_out_q;
    logic [N_UNITS*CONF_WIDTH-1:0]  conf_out_q;
    int                     idx;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + PTR_W'(1);
    endfunction

    // A unit that just got a start pulse is blanked while its busy rises
    assign elig = ~busy_i & ~start_q;

    always_comb begin
        sel      = '0;
        any_elig = 1'b0;
        idx      = 0;
        for (int i = 0; i < N_UNITS; i++) begin
            idx = (int'(rr_ptr) + i) % N_UNITS;
            if (!any_elig && elig[idx]) begin
                any_elig = 1'b1;
                sel      = UNIT_W'(idx);
            end
        end
    end

`ifdef QUADRILATERO_LSU_FALL_THROUGH_EN
    logic bypass;
    assign bypass     = (count == '0) && dispatch_i;
    assign has_head   = (count != '0) || dispatch_i;
    assign head_instr = bypass ? dispatched_instr_i : instr_q[rd_ptr];
    assign head_conf  = bypass ? csr_config_i : conf_q[rd_ptr];
`else
    assign has_head   = count != '0;
    assign head_instr = instr_q[rd_ptr];
    assign head_conf  = conf_q[rd_ptr];
`endif

    assign pop  = has_head && !flush_i && any_elig;
    assign push = dispatch_i && !flush_i && ((count != SLOTS) || pop);

    always_ff @(posedge clk_i) begin
        if (push) begin
            instr_q[wr_ptr] <= dispatched_instr_i;
            conf_q[wr_ptr]  <= csr_config_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            overflow_q  <= 1'b0;
            rr_ptr      <= '0;
            start_q     <= '0;
            instr_out_q <= '0;
            conf_out_q  <= '0;
        end else begin
            if (flush_i) begin
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                overflow_q <= 1'b0;
            end else begin
                if (push) wr_ptr <= nxt(wr_ptr);
                if (pop)  rd_ptr <= nxt(rd_ptr);
                if (push && !pop)
                    count <= count + CNT_W'(1);
                else if (pop && !push)
                    count <= count - CNT_W'(1);
                if (dispatch_i && !push) overflow_q <= 1'b1;
            end
            start_q <= '0;
            if (pop) begin
                start_q[sel] <= 1'b1;
                instr_out_q[sel*INSTR_WIDTH +: INSTR_WIDTH] <= head_instr;
                conf_out_q[sel*CONF_WIDTH +: CONF_WIDTH]    <= head_conf;
                rr_ptr <= (sel == LAST_UNIT) ? '0 : sel + UNIT_W'(1);
            end
        end
    end

    assign start_o             = start_q;
    assign issued_instr_o      = instr_out_q;
    assign issued_instr_conf_o = conf_out_q;
    assign usage_o             = count;
    assign overflow_o          = overflow_q;
    assign issue_queue_full_o  = count >= FULL_THR;

endmodule

// File: tb/tb_quadrilatero_lsu_issue_ctrl.sv
// Directed bench for quadrilatero_lsu_issue_ctrl (N_SLOTS=4, N_UNITS=2).
// Expected values below are hand-derived cycle by cycle.
module tb_quadrilatero_lsu_issue_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        flush_i = 1'b0;
    logic        dispatch_i = 1'b0;
    logic [31:0] dispatched_instr_i = '0;
    logic [31:0] csr_config_i = '0;
    logic        issue_queue_full_o;
    logic [2:0]  usage_o;
    logic        overflow_o;
    logic [1:0]  busy_i = '0;
    logic [1:0]  start_o;
    logic [63:0] issued_instr_o;
    logic [63:0] issued_instr_conf_o;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk_i = ~clk_i;

    quadrilatero_lsu_issue_ctrl #(
        .N_SLOTS(4), .N_UNITS(2), .INSTR_WIDTH(32),
        .CONF_WIDTH(32), .FULL_MARGIN(1)
    ) dut (
        .clk_i(clk_i),
        .rst_ni(rst_ni),
        .flush_i(flush_i),
        .dispatch_i(dispatch_i),
        .dispatched_instr_i(dispatched_instr_i),
        .csr_config_i(csr_config_i),
        .issue_queue_full_o(issue_queue_full_o),
        .usage_o(usage_o),
        .overflow_o(overflow_o),
        .busy_i(busy_i),
        .start_o(start_o),
        .issued_instr_o(issued_instr_o),
        .issued_instr_conf_o(issued_instr_conf_o)
    );

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_start"}, 64'(start_o), 64'h0);
        chk({tag, "_instr"}, issued_instr_o, 64'h0);
        chk({tag, "_conf"}, issued_instr_conf_o, 64'h0);
        chk({tag, "_usage"}, 64'(usage_o), 64'h0);
        chk({tag, "_ovf"}, 64'(overflow_o), 64'h0);
        chk({tag, "_full"}, 64'(issue_queue_full_o), 64'h0);
    endtask

    initial begin
        tick();
        tick();
        chk_all_zero("reset");
        rst_ni = 1'b1;

        // back-to-back A, B, C with both units idle
        dispatch_i = 1'b1;
        dispatched_instr_i = 32'hA0A0_A0A0;
        csr_config_i = 32'h1;
        tick();
        dispatched_instr_i = 32'hB0B0_B0B0;
        tick();
        chk("t1_start_a", 64'(start_o), 64'h1);
        chk("t1_slot0_a", 64'(issued_instr_o[31:0]), 64'hA0A0_A0A0);
        chk("t1_usage1", 64'(usage_o), 64'h1);
        dispatched_instr_i = 32'hC0C0_C0C0;
        tick();
        chk("t1_start_b", 64'(start_o), 64'h2);
        chk("t1_slot1_b", 64'(issued_instr_o[63:32]), 64'hB0B0_B0B0);
        chk("t1_slot0_hold", 64'(issued_instr_o[31:0]), 64'hA0A0_A0A0);
        dispatch_i = 1'b0;
        tick();
        chk("t1_start_c", 64'(start_o), 64'h1);
        chk("t1_slot0_c", 64'(issued_instr_o[31:0]), 64'hC0C0_C0C0);
        chk("t1_usage0", 64'(usage_o), 64'h0);
        tick();
        chk("t1_idle", 64'(start_o), 64'h0);
        chk("t1_slot1_hold", 64'(issued_instr_o[63:32]), 64'hB0B0_B0B0);

        // conf captured at dispatch time
        busy_i = 2'b11;
        dispatch_i = 1'b1;
        dispatched_instr_i = 32'h0000_00A2;
        csr_config_i = 32'h11;
        tick();
        dispatched_instr_i = 32'h0000_00B2;
        csr_config_i = 32'h22;
        tick();
        dispatch_i = 1'b0;
        csr_config_i = 32'h99;
        busy_i = 2'b00;
        chk("t2_usage2", 64'(usage_o), 64'h2);
        tick();
        chk("t2_start_a", 64'(start_o), 64'h2);
        chk("t2_instr_a", 64'(issued_instr_o[63:32]), 64'hA2);
        chk("t2_conf_a", 64'(issued_instr_conf_o[63:32]), 64'h11);
        tick();
        chk("t2_start_b", 64'(start_o), 64'h1);
        chk("t2_instr_b", 64'(issued_instr_o[31:0]), 64'hB2);
        chk("t2_conf_b", 64'(issued_instr_conf_o[31:0]), 64'h22);
        tick();
        chk("t2_idle", 64'(start_o), 64'h0);

        // fill, full threshold, overflow
        busy_i = 2'b11;
        dispatch_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dispatched_instr_i = 32'hD000_0000 + 32'(i);
            tick();
            if (i == 1) begin
                chk("t3_usage2", 64'(usage_o), 64'h2);
                chk("t3_full_off", 64'(issue_queue_full_o), 64'h0);
            end
            if (i == 2) begin
                chk("t3_usage3", 64'(usage_o), 64'h3);
                chk("t3_full_on", 64'(issue_queue_full_o), 64'h1);
            end
            if (i == 3) begin
                chk("t3_usage4", 64'(usage_o), 64'h4);
                chk("t3_ovf_off", 64'(overflow_o), 64'h0);
            end
            if (i == 4) begin
                chk("t3_usage_sat", 64'(usage_o), 64'h4);
                chk("t3_ovf_on", 64'(overflow_o), 64'h1);
            end
        end

        // flush with a simultaneous dispatch
        flush_i = 1'b1;
        dispatched_instr_i = 32'hFFFF_0000;
        tick();
        flush_i = 1'b0;
        dispatch_i = 1'b0;
        busy_i = 2'b00;
        chk("fl_usage", 64'(usage_o), 64'h0);
        chk("fl_ovf", 64'(overflow_o), 64'h0);
        chk("fl_full", 64'(issue_queue_full_o), 64'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_start", 64'(start_o), 64'h0);
            chk("fl_usage_stay", 64'(usage_o), 64'h0);
        end
        chk("fl_slot1_hold", 64'(issued_instr_o[63:32]), 64'hA2);

        // unit 0 permanently busy: every issue goes to unit 1
        busy_i = 2'b01;
        for (int i = 0; i < 9; i++) begin
            dispatch_i = (i < 4);
            dispatched_instr_i = 32'hE000_0000 + 32'(i);
            tick();
            if (i >= 1)
                chk("t4_start", 64'(start_o),
                    (i % 2 == 1) ? 64'h2 : 64'h0);
            if (i % 2 == 1)
                chk("t4_slot1", 64'(issued_instr_o[63:32]),
                    64'hE000_0000 + 64'((i - 1) / 2));
        end
        chk("t4_usage0", 64'(usage_o), 64'h0);

        // asynchronous reset mid-stream
        busy_i = 2'b11;
        dispatch_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dispatched_instr_i = 32'h6000_0000 + 32'(i);
            tick();
        end
        dispatch_i = 1'b0;
        busy_i = 2'b10;
        tick();
        chk("t5_pre_start", 64'(start_o), 64'h1);
        chk("t5_pre_usage", 64'(usage_o), 64'h2);
        rst_ni = 1'b0;
        #1;
        chk_all_zero("t5_rst");
        #1;
        rst_ni = 1'b1;
        busy_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_no_stale", 64'(start_o), 64'h0);
            chk("t5_usage", 64'(usage_o), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
